// File: rtl/circuito_exp3.sv
// Sequence-checking game: FSM control unit plus counter/ROM/switch-register datapath.
// Define DB_7SEG_EN to drive the db_* nibble outputs as active-low 7-segment codes.
module circuito_exp3 (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] chaves,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       db_igual,
  output logic       db_iniciar,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_chaves,
  output logic [6:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_ERROU   = 4'hE
  } estado_t;

  estado_t    r_estado;
  estado_t    w_proximo_estado;
  logic [3:0] r_contador;
  logic [3:0] r_chaves;
  logic [3:0] w_memoria;
  logic [3:0] w_estado_cod;
  logic       w_igual;

`ifdef DB_7SEG_EN
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction
`endif

  // Expected sequence, read asynchronously at the current round
  always_comb begin
    case (r_contador)
      4'h0: w_memoria = 4'h1;
      4'h1: w_memoria = 4'h2;
      4'h2: w_memoria = 4'h4;
      4'h3: w_memoria = 4'h8;
      4'h4: w_memoria = 4'h4;
      4'h5: w_memoria = 4'h2;
      4'h6: w_memoria = 4'h1;
      4'h7: w_memoria = 4'h1;
      4'h8: w_memoria = 4'h2;
      4'h9: w_memoria = 4'h2;
      4'hA: w_memoria = 4'h4;
      4'hB: w_memoria = 4'h4;
      4'hC: w_memoria = 4'h8;
      4'hD: w_memoria = 4'h8;
      4'hE: w_memoria = 4'h1;
      4'hF: w_memoria = 4'h4;
      default: w_memoria = 4'h0;
    endcase
  end

  assign w_igual = (r_chaves == w_memoria);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_proximo_estado;
    end
  end

  // iniciar is only looked at while idle or finished, so holding it never restarts a game
  always_comb begin
    w_proximo_estado = INICIAL;
    case (r_estado)
      INICIAL:     w_proximo_estado = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:  w_proximo_estado = REGISTRA;
      REGISTRA:    w_proximo_estado = COMPARACAO;
      COMPARACAO: begin
        if (!w_igual) begin
          w_proximo_estado = FIM_ERROU;
        end else if (r_contador == 4'hF) begin
          w_proximo_estado = FIM_ACERTOU;
        end else begin
          w_proximo_estado = PROXIMO;
        end
      end
      PROXIMO:     w_proximo_estado = REGISTRA;
      FIM_ACERTOU: w_proximo_estado = iniciar ? PREPARACAO : FIM_ACERTOU;
      FIM_ERROU:   w_proximo_estado = iniciar ? PREPARACAO : FIM_ERROU;
      default:     w_proximo_estado = INICIAL;
    endcase
  end

  // Datapath updates happen on the edge that leaves the controlling state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_contador <= 4'h0;
      r_chaves   <= 4'h0;
    end else begin
      case (r_estado)
        PREPARACAO: begin
          r_contador <= 4'h0;
          r_chaves   <= 4'h0;
        end
        REGISTRA: r_chaves   <= chaves;
        PROXIMO:  r_contador <= r_contador + 4'd1;
        default: begin
          r_contador <= r_contador;
          r_chaves   <= r_chaves;
        end
      endcase
    end
  end

  assign w_estado_cod = r_estado;
  assign acertou      = (r_estado == FIM_ACERTOU);
  assign errou        = (r_estado == FIM_ERROU);
  assign pronto       = acertou | errou;
  assign db_igual     = w_igual;
  assign db_iniciar   = iniciar;

`ifdef DB_7SEG_EN
  assign db_contagem = hex7seg(r_contador);
  assign db_memoria  = hex7seg(w_memoria);
  assign db_chaves   = hex7seg(r_chaves);
  assign db_estado   = hex7seg(w_estado_cod);
`else
  assign db_contagem = {3'b000, r_contador};
  assign db_memoria  = {3'b000, w_memoria};
  assign db_chaves   = {3'b000, r_chaves};
  assign db_estado   = {3'b000, w_estado_cod};
`endif

endmodule

// File: tb/tb_circuito_exp3.sv
// Directed self-checking bench for circuito_exp3 (works with or without DB_7SEG_EN).
module tb_circuito_exp3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [3:0] chaves = 4'h0;
  logic       pronto, acertou, errou, db_igual, db_iniciar;
  logic [6:0] db_contagem, db_memoria, db_chaves, db_estado;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] seq [16];

  circuito_exp3 dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .pronto(pronto), .acertou(acertou), .errou(errou),
    .db_igual(db_igual), .db_iniciar(db_iniciar),
    .db_contagem(db_contagem), .db_memoria(db_memoria),
    .db_chaves(db_chaves), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] enc(input logic [3:0] v);
`ifdef DB_7SEG_EN
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000; 4'h1: s = 7'b1111001; 4'h2: s = 7'b0100100; 4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001; 4'h5: s = 7'b0010010; 4'h6: s = 7'b0000010; 4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000; 4'h9: s = 7'b0010000; 4'hA: s = 7'b0001000; 4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110; 4'hD: s = 7'b0100001; 4'hE: s = 7'b0000110; 4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
`else
    return {3'b000, v};
`endif
  endfunction

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic [3:0] st,
                             input logic p, input logic a, input logic e);
    check_val({tag, "_estado"}, {1'b0, db_estado}, {1'b0, enc(st)});
    check_val({tag, "_flags"}, {5'b0, pronto, acertou, errou}, {5'b0, p, a, e});
  endtask

  // Entered in registra: applies val, checks registra and comparacao, leaves after comparacao
  task automatic play_round(input int k, input logic [3:0] val);
    chaves = val;
    check_val("reg_estado", {1'b0, db_estado}, {1'b0, enc(4'h4)});
    check_val("reg_contagem", {1'b0, db_contagem}, {1'b0, enc(4'(k))});
    check_val("reg_memoria", {1'b0, db_memoria}, {1'b0, enc(seq[k])});
    check_val("reg_flags", {5'b0, pronto, acertou, errou}, 8'h00);
    tick();
    check_val("cmp_estado", {1'b0, db_estado}, {1'b0, enc(4'h5)});
    check_val("cmp_chaves", {1'b0, db_chaves}, {1'b0, enc(val)});
    check_val("cmp_igual", {7'b0, db_igual}, {7'b0, val == seq[k]});
    tick();
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    tick();
    check_val("prep_estado", {1'b0, db_estado}, {1'b0, enc(4'h1)});
    check_val("db_iniciar", {7'b0, db_iniciar}, 8'h01);
    tick();
  endtask

  initial begin
    seq[0] = 4'h1; seq[1] = 4'h2; seq[2] = 4'h4; seq[3] = 4'h8;
    seq[4] = 4'h4; seq[5] = 4'h2; seq[6] = 4'h1; seq[7] = 4'h1;
    seq[8] = 4'h2; seq[9] = 4'h2; seq[10] = 4'h4; seq[11] = 4'h4;
    seq[12] = 4'h8; seq[13] = 4'h8; seq[14] = 4'h1; seq[15] = 4'h4;

    // reset state
    tick();
    reset = 1'b0;
    #1;
    check_flags("rst", 4'h0, 1'b0, 1'b0, 1'b0);
    check_val("rst_contagem", {1'b0, db_contagem}, {1'b0, enc(4'h0)});
    check_val("rst_memoria", {1'b0, db_memoria}, {1'b0, enc(4'h1)});
    check_val("rst_chaves", {1'b0, db_chaves}, {1'b0, enc(4'h0)});
    check_val("db_iniciar0", {7'b0, db_iniciar}, 8'h00);

    // idle in inicial without iniciar
    for (int i = 0; i < 10; i++) begin
      tick();
      check_flags("idle", 4'h0, 1'b0, 1'b0, 1'b0);
    end

    // full correct game, iniciar held high through most of it
    start_game();
    for (int k = 0; k < 16; k++) begin
      if (k == 15) iniciar = 1'b0;
      play_round(k, seq[k]);
      if (k < 15) begin
        check_flags("prox", 4'h6, 1'b0, 1'b0, 1'b0);
        tick();
      end
    end
    check_flags("win", 4'hA, 1'b1, 1'b1, 1'b0);
    check_val("win_contagem", {1'b0, db_contagem}, {1'b0, enc(4'hF)});
    for (int i = 0; i < 10; i++) begin
      tick();
      check_flags("win_hold", 4'hA, 1'b1, 1'b1, 1'b0);
    end

    // restart, wrong value in round 2
    start_game();
    iniciar = 1'b0;
    check_val("restart_contagem", {1'b0, db_contagem}, {1'b0, enc(4'h0)});
    check_val("restart_chaves", {1'b0, db_chaves}, {1'b0, enc(4'h0)});
    for (int k = 0; k < 2; k++) begin
      play_round(k, seq[k]);
      tick();
    end
    play_round(2, 4'h2);
    check_flags("lose", 4'hE, 1'b1, 1'b0, 1'b1);
    check_val("lose_contagem", {1'b0, db_contagem}, {1'b0, enc(4'h2)});
    for (int i = 0; i < 10; i++) begin
      tick();
      check_flags("lose_hold", 4'hE, 1'b1, 1'b0, 1'b1);
    end

    // reset mid-game at contador 5
    start_game();
    iniciar = 1'b0;
    for (int k = 0; k < 5; k++) begin
      play_round(k, seq[k]);
      tick();
    end
    check_val("mid_contagem", {1'b0, db_contagem}, {1'b0, enc(4'h5)});
    #2;
    reset = 1'b1;
    #1;
    check_flags("mid_rst", 4'h0, 1'b0, 1'b0, 1'b0);
    check_val("mid_rst_contagem", {1'b0, db_contagem}, {1'b0, enc(4'h0)});
    check_val("mid_rst_memoria", {1'b0, db_memoria}, {1'b0, enc(4'h1)});
    check_val("mid_rst_chaves", {1'b0, db_chaves}, {1'b0, enc(4'h0)});
    tick();
    reset = 1'b0;
    tick();
    check_flags("post_rst", 4'h0, 1'b0, 1'b0, 1'b0);

    // fresh game after reset
    start_game();
    iniciar = 1'b0;
    for (int k = 0; k < 16; k++) begin
      play_round(k, seq[k]);
      if (k < 15) tick();
    end
    check_flags("win2", 4'hA, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
